// File: rtl/stream_frame_grabber.sv
// stream_frame_grabber
// Recovers the Game-of-Life grid from the packed 32-bit RGB video stream.
// Every 3 stream words carry 4 pixels. Each pixel is thresholded to one
// cell bit, and each completed row is presented on a valid/ready line port
// together with its row address.
//
// Ports:
//   in_stream_aclk    clock; all logic uses its rising edge
//   periph_reset      synchronous, active-high reset
//   in_stream_t*      AXI-Stream slave (tkeep ignored, tuser = start of
//                     frame, tlast = end of row)
//   line_data         row cells, pixel x at bit X_SIZE-1-x
//   line_addr         row index of line_data
//   line_valid/ready  row handshake; data is held until accepted
//   frame_done        pulse while the last row of a frame is accepted
//   err_sof, err_eol  sticky framing errors, cleared by reset only
module stream_frame_grabber #(
  parameter int unsigned X_SIZE         = 1280,
  parameter int unsigned Y_SIZE         = 720,
  parameter int unsigned WORDS_PER_LINE = X_SIZE * 3 / 4
) (
  input  logic              in_stream_aclk,
  input  logic              periph_reset,
  input  logic [31:0]       in_stream_tdata,
  input  logic [3:0]        in_stream_tkeep,
  input  logic              in_stream_tlast,
  input  logic              in_stream_tuser,
  input  logic              in_stream_tvalid,
  output logic              in_stream_tready,
  output logic [X_SIZE-1:0] line_data,
  output logic [9:0]        line_addr,
  output logic              line_valid,
  input  logic              line_ready,
  output logic              frame_done,
  output logic              err_sof,
  output logic              err_eol
);

  localparam int unsigned GRPS  = WORDS_PER_LINE / 3;
  localparam int unsigned GRP_W = (GRPS > 1) ? $clog2(GRPS) : 1;
  localparam int unsigned ROW_W = 10;
  localparam int unsigned PH_W  = 2;

  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GRPS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(Y_SIZE - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PH_W-1:0]   phase;
  logic [GRP_W-1:0]  grp;
  logic [ROW_W-1:0]  row;
  logic [31:0]       word0, word1;
  logic [X_SIZE-1:0] row_sr;

  // Position the accepted word is processed at (tuser forces row 0 word 0)
  logic [PH_W-1:0]   eff_phase;
  logic [GRP_W-1:0]  eff_grp;
  logic [ROW_W-1:0]  eff_row;
  logic              eff_last;

  logic              accept;
  logic              take_word;
  logic              load_line;
  logic              restart;
  logic              set_sof;
  logic              set_eol;
  logic              shift_en;
  logic              completing_next;

  logic [95:0]       group_bits;
  logic [3:0]        cells;
  logic [X_SIZE-1:0] row_sr_nxt;

  // tkeep carries no information for this stream
  logic unused_keep;
  assign unused_keep = ^in_stream_tkeep;

  // Stall only the row-completing word while the previous row is still held
  assign completing_next  = (phase == PH_LAST) && (grp == GRP_LAST);
  assign in_stream_tready = !periph_reset &&
                            !(line_valid && !line_ready && completing_next);
  assign accept           = in_stream_tvalid && in_stream_tready;

  // Threshold four pixels; P0 takes the highest new bit so it ends up at the MSB
  assign group_bits = {in_stream_tdata, word1, word0};
  assign cells[3]   = |group_bits[23:0];
  assign cells[2]   = |group_bits[47:24];
  assign cells[1]   = |group_bits[71:48];
  assign cells[0]   = |group_bits[95:72];
  assign row_sr_nxt = X_SIZE'({row_sr, cells});

  assign frame_done = line_valid && line_ready && (line_addr == ROW_LAST);

  // State register
  always_ff @(posedge in_stream_aclk) begin
    if (periph_reset) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-word control decode
  always_comb begin
    state_nxt = state;
    eff_phase = phase;
    eff_grp   = grp;
    eff_row   = row;
    take_word = 1'b0;
    load_line = 1'b0;
    restart   = 1'b0;
    set_sof   = 1'b0;
    set_eol   = 1'b0;

    if (accept) begin
      case (state)
        HUNT: begin
          if (in_stream_tuser) begin
            eff_phase = '0;
            eff_grp   = '0;
            eff_row   = '0;
            take_word = 1'b1;
            state_nxt = RECV;
          end
        end
        RECV: begin
          take_word = 1'b1;
          if (in_stream_tuser) begin
            if ((row != '0) || (phase != '0) || (grp != '0)) begin
              set_sof = 1'b1;
            end
            eff_phase = '0;
            eff_grp   = '0;
            eff_row   = '0;
          end
        end
        DRAIN: begin
          if (in_stream_tlast) begin
            state_nxt = RECV;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end

    eff_last = (eff_phase == PH_LAST) && (eff_grp == GRP_LAST);

    if (take_word) begin
      if (eff_last) begin
        // Row is emitted even when tlast is missing; the rest is drained
        load_line = 1'b1;
        if (!in_stream_tlast) begin
          set_eol   = 1'b1;
          state_nxt = DRAIN;
        end
      end else if (in_stream_tlast) begin
        // Early tlast: drop the partial row and restart the same row
        set_eol = 1'b1;
        restart = 1'b1;
      end
    end
  end

  assign shift_en = take_word && (eff_phase == PH_LAST) && !restart;

  // Counters, group staging, row shift register, output register and flags
  always_ff @(posedge in_stream_aclk) begin
    if (periph_reset) begin
      phase      <= '0;
      grp        <= '0;
      row        <= '0;
      word0      <= '0;
      word1      <= '0;
      row_sr     <= '0;
      line_valid <= 1'b0;
      line_data  <= '0;
      line_addr  <= '0;
      err_sof    <= 1'b0;
      err_eol    <= 1'b0;
    end else begin
      if (take_word) begin
        if (load_line) begin
          phase <= '0;
          grp   <= '0;
          row   <= (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
        end else if (restart) begin
          phase <= '0;
          grp   <= '0;
          row   <= eff_row;
        end else if (eff_phase == PH_LAST) begin
          phase <= '0;
          grp   <= eff_grp + GRP_W'(1);
          row   <= eff_row;
        end else begin
          phase <= eff_phase + PH_W'(1);
          grp   <= eff_grp;
          row   <= eff_row;
        end

        if (eff_phase == PH_W'(0)) begin
          word0 <= in_stream_tdata;
        end
        if (eff_phase == PH_W'(1)) begin
          word1 <= in_stream_tdata;
        end
        if (shift_en) begin
          row_sr <= row_sr_nxt;
        end
      end

      // A new row may load in the same cycle the held row is accepted
      if (load_line) begin
        line_valid <= 1'b1;
        line_data  <= row_sr_nxt;
        line_addr  <= eff_row;
      end else if (line_ready) begin
        line_valid <= 1'b0;
      end

      if (set_sof) begin
        err_sof <= 1'b1;
      end
      if (set_eol) begin
        err_eol <= 1'b1;
      end
    end
  end

endmodule

// File: doc/stream_frame_grabber.md
# stream_frame_grabber

- Receives the 32-bit AXI-Stream video produced by the pixel generator and its packer, and recovers the 1280×720 Game-of-Life grid.
- Unpacks 24-bit RGB pixels, thresholds each one to a 1-bit cell state, and assembles 1280-bit rows.
- Writes each row with its row address through a valid/ready line port into a grid BRAM.
- Sits at the far end of the video stream: loopback checking, frame capture, or feeding the next-state engine from displayed output.

## Interface

Parameters:
- X_SIZE, 1280: pixels per row; must be a multiple of 4.
- Y_SIZE, 720: rows per frame.
- WORDS_PER_LINE, X_SIZE*3/4 (960): stream words per row.

Ports:
- in_stream_aclk  in  1  sole clock; all logic on its rising edge.
- periph_reset  in  1  synchronous, active-high reset.
- in_stream_tdata  in  32  packed pixel data.
- in_stream_tkeep  in  4  ignored; all bytes treated valid.
- in_stream_tlast  in  1  last word of a row.
- in_stream_tuser  in  1  first word of a frame.
- in_stream_tvalid  in  1  word valid.
- in_stream_tready  out  1  word accepted when tvalid && tready.
- line_data  out  X_SIZE  row cells; pixel x at bit X_SIZE-1-x.
- line_addr  out  10  row index 0..Y_SIZE-1.
- line_valid  out  1  line_data/line_addr valid; held until accepted.
- line_ready  in  1  downstream accepts the row when line_valid && line_ready.
- frame_done  out  1  one-cycle pulse when row Y_SIZE-1 is accepted.
- err_sof  out  1  sticky: tuser seen away from row 0 word 0.
- err_eol  out  1  sticky: tlast position wrong.

## Operation

Packing:
- Each 4-pixel group P0..P3 arrives as 3 words; Pn = {r,g,b}, 8 bits each.
- Concatenation {P3,P2,P1,P0} = 96 bits; word0 = [31:0], word1 = [63:32], word2 = [95:64].
- Cell = 1 iff (r|g|b) != 0.

Counters:
- phase: 0..2, word within the group.
- grp: 0..X_SIZE/4-1, group within the row.
- row: 0..Y_SIZE-1.

State machine:
- HUNT, entered on reset: tready=1; words are discarded until an accepted word has tuser=1. That word is processed as row 0, word 0, and the state moves to RECV.
- RECV:
  - Words 0 and 1 of a group are stored.
  - On word 2, four cells are shifted into the 1280-bit row shift register, P0 first, so P0 lands at the MSB end at the end of the row.
  - On the word where grp=last and phase=2: if tlast=1, the row is moved to the output register.
- Wrong tlast position (row is still moved to the output register):
  - tlast=0 on the last word: set err_eol and go to DRAIN.
  - DRAIN discards words up to and including the next tlast, then returns to RECV. row has already advanced.
- Early tlast (before the last word):
  - Set err_eol, discard the partial row, and reset phase and grp.
  - row is unchanged; the next word starts the same row again.
- tuser=1 while in RECV at any position other than row 0 word 0:
  - Set err_sof and discard the partial row.
  - Process the word as row 0, word 0.
  - A pending output row is not affected.
- Row completion:
  - line_addr takes the current row, then row increments, wrapping to 0 after Y_SIZE-1.
  - frame_done pulses in the cycle the row Y_SIZE-1 output is accepted.

Backpressure:
- in_stream_tready = !periph_reset && !(line_valid && !line_ready && completing_word_next).
- completing_word_next means phase=2 and grp=last.
- Otherwise tready stays 1, so the stream is never stalled mid-row.
- If the output register frees and a new row completes in the same cycle, the new row is loaded.

## Timing

- Reset values: tready=0 while reset is asserted, and 1 in the cycle after reset deasserts. line_valid=0, line_data=0, line_addr=0, frame_done=0, err_sof=0, err_eol=0, state=HUNT, and all counters 0.
- Row latency: line_valid rises 1 cycle after the completing word is accepted.
- line_data and line_addr are stable while line_valid && !line_ready.
- Throughput: 1 word per cycle; a full frame is 691200 words.
- tvalid low: counters hold.
- Reset mid-row or mid-handshake: the partial row and any pending output are dropped, and the state returns to HUNT.
- Error flags clear only on reset.

## Test plan

- Reset, then one frame of all-dead pixels (every word 0) with correct tuser/tlast → 720 rows, line_addr 0..719, every line_data=0, one frame_done pulse, no errors.
- Frame where only x=0 and x=1279 have colour CB/41/6B in every row, line_ready=1 → each line_data = 1 at bits 1279 and 0, 0 elsewhere; first row's line_valid 1 cycle after word 960.
- 50 random words without tuser, then a valid frame → the 50 words are ignored; rows 0..719 are captured correctly.
- tlast asserted on word 500 of row 3 → err_eol=1; row 3 is re-captured from the next 960-word row; line_addr sequence continues at 3.
- line_ready held 0 for 2000 cycles after row 0 completes → tready drops only on row 1's final word; row 0 is held unchanged; row 1 is output once row 0 is accepted.
- tuser pulsed at row 10 word 0 → err_sof=1; the next captured row has line_addr=0.
